// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a MEM-stage data access and the following instruction fetch.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_start,
  input  logic        core_end,
  input  logic [31:0] if_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] instr_if,
  output logic [31:0] d_rdata,
  output logic        data_ready_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] if_a, d_a, wd;
  logic        rd, wr, go, busy, tout;
  logic [7:0]  cnt;
  assign go   = core_start && !core_end;
  assign busy = state == DACC || state == IACC;
  // An ack in the deadline cycle beats the timeout.
  assign tout = busy && !mem_ack && ({1'b0, cnt} + 9'd1 >= 9'(TIMEOUT));
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (go ? ((d_read || d_write) ? DACC : IACC) : IDLE)
             : state == DACC ? (mem_ack ? IACC : (tout ? DONE : DACC))
             : state == IACC ? ((mem_ack || tout) ? DONE : IACC)
             : IDLE;
  end
  always_comb begin
    mem_req        = busy;
    mem_we         = state == DACC && wr;
    data_ready_mem = state == DONE;
    mem_addr       = state == DACC ? d_a : if_a;
    mem_wdata      = wd;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      if_a     <= '0;
      d_a      <= '0;
      wd       <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      cnt      <= '0;
      instr_if <= '0;
      d_rdata  <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        if_a <= if_addr;
        d_a  <= d_addr;
        wd   <= d_wdata;
        rd   <= d_read;
        wr   <= d_write;
      end
      cnt <= (busy && state_nx == state) ? cnt + 8'(cnt != 8'hff) : '0;
      if (state == DACC && rd && !wr && (mem_ack || tout)) d_rdata <= mem_ack ? mem_rdata : '0;
      if (state == IACC && (mem_ack || tout)) instr_if <= mem_ack ? mem_rdata : '0;
      if (tout) mem_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of mem_port_arbiter with TIMEOUT=4.
module tb_mem_port_arbiter;
  logic        clk = 0, rstn = 0, core_start = 0, core_end = 0;
  logic        d_read = 0, d_write = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] instr_if, d_rdata, mem_addr, mem_wdata;
  logic        data_ready_mem, mem_req, mem_we, mem_err;
  int          total_n = 0, pass_n = 0;
  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .core_start(core_start), .core_end(core_end),
    .if_addr(if_addr), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .instr_if(instr_if), .d_rdata(d_rdata),
    .data_ready_mem(data_ready_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    tick;
    tick;
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_drm", 32'(data_ready_mem), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_instr", instr_if, 0);
    check("rst_drdata", d_rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rstn = 1;
    tick;
    // fetch only, zero wait
    core_start = 1; if_addr = 32'h40;
    tick;
    check("f_req", 32'(mem_req), 1);
    check("f_addr", mem_addr, 32'h40);
    check("f_we", 32'(mem_we), 0);
    check("f_drm_early", 32'(data_ready_mem), 0);
    core_start = 0; mem_ack = 1; mem_rdata = 32'h00500093;
    tick;
    check("f_drm", 32'(data_ready_mem), 1);
    check("f_instr", instr_if, 32'h00500093);
    check("f_req_done", 32'(mem_req), 0);
    mem_ack = 0;
    tick;
    check("f_drm_off", 32'(data_ready_mem), 0);
    check("f_idle_req", 32'(mem_req), 0);
    // store, two wait cycles, then fetch
    core_start = 1; d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; if_addr = 32'h44;
    tick;
    check("s_req", 32'(mem_req), 1);
    check("s_we", 32'(mem_we), 1);
    check("s_addr", mem_addr, 32'h100);
    check("s_wdata", mem_wdata, 32'hDEADBEEF);
    core_start = 0; d_write = 0; d_addr = 32'h999; d_wdata = 0; if_addr = 32'h888;
    tick;
    check("s_addr_hold", mem_addr, 32'h100);
    check("s_wdata_hold", mem_wdata, 32'hDEADBEEF);
    tick;
    check("s_we_hold", 32'(mem_we), 1);
    mem_ack = 1; mem_rdata = 32'hAAAA5555;
    tick;
    check("s_iacc_we", 32'(mem_we), 0);
    check("s_iacc_addr", mem_addr, 32'h44);
    check("s_drdata", d_rdata, 0);
    check("s_drm_early", 32'(data_ready_mem), 0);
    mem_rdata = 32'h00000013;
    tick;
    check("s_drm", 32'(data_ready_mem), 1);
    check("s_instr", instr_if, 32'h13);
    mem_ack = 0;
    tick;
    // load
    core_start = 1; d_read = 1; d_addr = 32'h200; if_addr = 32'h48;
    tick;
    check("l_we", 32'(mem_we), 0);
    check("l_addr", mem_addr, 32'h200);
    core_start = 0; d_read = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    tick;
    check("l_drdata", d_rdata, 32'h12345678);
    check("l_iaddr", mem_addr, 32'h48);
    mem_rdata = 32'h00A00113;
    tick;
    check("l_drm", 32'(data_ready_mem), 1);
    check("l_instr", instr_if, 32'h00A00113);
    mem_ack = 0;
    tick;
    check("l_drm_once", 32'(data_ready_mem), 0);
    // read and write together: the write wins
    core_start = 1; d_read = 1; d_write = 1; d_addr = 32'h300; d_wdata = 32'h55;
    tick;
    check("rw_we", 32'(mem_we), 1);
    core_start = 0; d_read = 0; d_write = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick;
    check("rw_drdata", d_rdata, 32'h12345678);
    mem_rdata = 32'h33;
    tick;
    check("rw_instr", instr_if, 32'h33);
    mem_ack = 0;
    tick;
    // ack in the deadline cycle beats the timeout
    core_start = 1; if_addr = 32'h50;
    tick;
    core_start = 0;
    tick;
    tick;
    tick;
    check("aw_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h77;
    tick;
    check("aw_drm", 32'(data_ready_mem), 1);
    check("aw_instr", instr_if, 32'h77);
    check("aw_err", 32'(mem_err), 0);
    mem_ack = 0;
    tick;
    // fetch timeout
    core_start = 1; if_addr = 32'h4C;
    tick;
    core_start = 0;
    check("to_err_early", 32'(mem_err), 0);
    tick;
    tick;
    tick;
    check("to_req_w4", 32'(mem_req), 1);
    check("to_err_w4", 32'(mem_err), 0);
    tick;
    check("to_err", 32'(mem_err), 1);
    check("to_drm", 32'(data_ready_mem), 1);
    check("to_instr", instr_if, 0);
    check("to_req", 32'(mem_req), 0);
    tick;
    check("to_drm_once", 32'(data_ready_mem), 0);
    check("to_err_sticky", 32'(mem_err), 1);
    // load timeout skips the fetch
    core_start = 1; d_read = 1; d_addr = 32'h400; if_addr = 32'h5C;
    tick;
    core_start = 0; d_read = 0;
    check("dto_addr", mem_addr, 32'h400);
    tick;
    tick;
    tick;
    tick;
    check("dto_drm", 32'(data_ready_mem), 1);
    check("dto_req", 32'(mem_req), 0);
    check("dto_drdata", d_rdata, 0);
    tick;
    check("dto_err_sticky", 32'(mem_err), 1);
    // core_end during a data access
    core_start = 1; d_write = 1; d_addr = 32'h500; if_addr = 32'h54;
    tick;
    d_write = 0; core_end = 1;
    tick;
    check("ce_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h99;
    tick;
    check("ce_iaddr", mem_addr, 32'h54);
    tick;
    check("ce_drm", 32'(data_ready_mem), 1);
    check("ce_instr", instr_if, 32'h99);
    mem_ack = 0;
    tick;
    check("ce_idle_req", 32'(mem_req), 0);
    check("ce_drm_once", 32'(data_ready_mem), 0);
    tick;
    check("ce_hold_req", 32'(mem_req), 0);
    // reset during a fetch, then a late ack
    core_end = 0; if_addr = 32'h60;
    tick;
    check("rm_req", 32'(mem_req), 1);
    core_start = 0; rstn = 0;
    tick;
    check("rm_req_drop", 32'(mem_req), 0);
    check("rm_err", 32'(mem_err), 0);
    rstn = 1; mem_ack = 1; mem_rdata = 32'hBAD;
    tick;
    check("rm_late_instr", instr_if, 0);
    check("rm_late_req", 32'(mem_req), 0);
    check("rm_late_drm", 32'(data_ready_mem), 0);
    mem_ack = 0;
    tick;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
